registro_entradas_multi: RTL and testbench

Multi-channel input register bank: C channels of N bits, each sampled under its own enable, each holding its last accepted value. Every accepted change sets a sticky per-channel flag and queues a {channel, value} event into a small FIFO drained by a valid/ready consumer. It sits between the raw input pins/decoders and the control FSM, replacing the single free-running input register with change-driven event delivery.

---
 rtl/registro_entradas_multi_pkg.sv | 21 ++
 rtl/registro_entradas_multi_fifo.sv | 60 ++++++
 rtl/registro_entradas_multi.sv | 169 ++++++++++++++++
 tb/tb_registro_entradas_multi.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/registro_entradas_multi_pkg.sv
// rtl/registro_entradas_multi_pkg.sv - shared widths and constants for registro_entradas_multi
package registro_pkg;

    // Channel index width; a single-channel bank still carries a 1-bit index.
    function automatic int calc_cw(input int c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    // Width of one queued event record: {channel index, value}.
    function automatic int calc_rec_w(input int c, input int n);
        return calc_cw(c) + n;
    endfunction

    localparam int N_DEF     = 25;
    localparam int C_DEF     = 4;
    localparam int REC_W_DEF = calc_rec_w(C_DEF, N_DEF);

    // Value every channel register returns to on reset (replicated to N bits).
    localparam logic REG_RST_BIT = 1'b0;

endpackage

// File: rtl/registro_entradas_multi_fifo.sv
// rtl/registro_entradas_multi_fifo.sv - first-word-fall-through event FIFO with simultaneous push/pop
module fifo_eventos
    import registro_pkg::*;
#(
    parameter int W = REC_W_DEF,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_tdata,
    input  logic         in_tvalid,
    output logic [W-1:0] out_tdata,
    input  logic         out_tready,
    output logic         full,
    output logic         empty
);

    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = out_tready && !empty;
    assign do_push = in_tvalid && (!full || do_pop);

    // Head is presented combinationally; an empty FIFO shows zero.
    assign out_tdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since empty masks the output.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= in_tdata;
        end
    end

    // Pointer advance on accepted push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/registro_entradas_multi.sv
// rtl/registro_entradas_multi.sv - multi-channel input register bank with change-event FIFO; optional filter macro REGISTRO_ENTRADAS_FILTRO_EN
module registro_entradas_multi
    import registro_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int C = C_DEF,
    parameter int D = 8,
    parameter int F = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [C*N-1:0]         In,
    input  logic [C-1:0]           Enable,
    output logic [C*N-1:0]         Signreg,
    output logic [C-1:0]           Cambio,
    input  logic [C-1:0]           Clear,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [calc_cw(C)-1:0]  ev_canal,
    output logic [N-1:0]           ev_dato,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int CW   = calc_cw(C);
    localparam int EV_W = calc_rec_w(C, N);

    // A misconfigured instance never captures, so the fault is obvious at once.
    localparam bit CFG_OK = (F >= 1) && (D >= 2) && ((D & (D - 1)) == 0);

    logic [N-1:0]    samp [C];
    logic [N-1:0]    regv [C];
    logic [C-1:0]    cap;
    logic [C-1:0]    pend;
    logic [C-1:0]    grant;
    logic [C-1:0]    pushed;
    logic [CW-1:0]   grant_idx;
    logic [N-1:0]    grant_dat;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push_ok;
    logic            coal;
    logic [EV_W-1:0] fifo_data;

    for (genvar c = 0; c < C; c++) begin : g_chan
        assign samp[c]           = In[c*N +: N];
        assign Signreg[c*N +: N] = regv[c];
    end

`ifdef REGISTRO_ENTRADAS_FILTRO_EN
    localparam int FCW = (F > 1) ? $clog2(F) : 1;

    logic [N-1:0]   cand [C];
    logic [FCW-1:0] cnt  [C];
    logic [C-1:0]   match;

    // Capture once the same differing value has been seen on F consecutive enabled samples.
    always_comb begin
        match = '0;
        cap   = '0;
        for (int c = 0; c < C; c++) begin
            match[c] = (samp[c] == cand[c]) && (cnt[c] != '0);
            if (CFG_OK && Enable[c] && (samp[c] != regv[c])) begin
                cap[c] = (F == 1) || (match[c] && (cnt[c] == FCW'(F - 1)));
            end
        end
    end

    // Candidate value and run length per channel; a disabled sample leaves both frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < C; c++) begin
                cand[c] <= {N{REG_RST_BIT}};
                cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < C; c++) begin
                if (Enable[c]) begin
                    if ((samp[c] == regv[c]) || cap[c]) begin
                        cnt[c] <= '0;
                    end else if (match[c]) begin
                        cnt[c] <= cnt[c] + FCW'(1);
                    end else begin
                        cand[c] <= samp[c];
                        cnt[c]  <= FCW'(1);
                    end
                end
            end
        end
    end
`else
    // Capture on the first enabled sample that differs from the held value.
    always_comb begin
        cap = '0;
        for (int c = 0; c < C; c++) begin
            cap[c] = CFG_OK && Enable[c] && (samp[c] != regv[c]);
        end
    end
`endif

    // Fixed-priority arbiter: lowest-index pending channel is offered to the FIFO.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_dat = '0;
        for (int c = C - 1; c >= 0; c--) begin
            if (pend[c]) begin
                grant     = '0;
                grant[c]  = 1'b1;
                grant_idx = CW'(c);
                grant_dat = regv[c];
            end
        end
    end

    assign ev_valid = !fifo_empty;
    assign push_ok  = !fifo_full || (ev_valid && ev_ready);
    assign pushed   = push_ok ? grant : '0;

    // A channel whose old value leaves this cycle is not coalesced: the new
    // capture simply re-arms pend. Only a capture onto an unserved pend merges.
    assign coal = |(cap & pend & ~pushed);

    fifo_eventos #(
        .W (EV_W),
        .D (D)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .in_tdata   ({grant_idx, grant_dat}),
        .in_tvalid  (|pend),
        .out_tdata  (fifo_data),
        .out_tready (ev_ready),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign ev_canal = fifo_data[EV_W-1 -: CW];
    assign ev_dato  = fifo_data[N-1:0];

    // Channel registers take the sampled value on capture and hold otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < C; c++) begin
                regv[c] <= {N{REG_RST_BIT}};
            end
        end else begin
            for (int c = 0; c < C; c++) begin
                if (cap[c]) begin
                    regv[c] <= samp[c];
                end
            end
        end
    end

    // Pending, sticky change and overflow flags; a set always beats its clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend     <= '0;
            Cambio   <= '0;
            overflow <= 1'b0;
        end else begin
            pend     <= (pend & ~pushed) | cap;
            Cambio   <= (Cambio & ~Clear) | cap;
            overflow <= coal | (overflow & ~clr_overflow);
        end
    end

endmodule

// File: tb/tb_registro_entradas_multi.sv
// tb/tb_registro_entradas_multi.sv - self-checking bench for registro_entradas_multi
module tb_registro_entradas_multi;

    localparam int N  = 25;
    localparam int C  = 4;
    localparam int D  = 8;
    localparam int F  = 3;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
`ifdef REGISTRO_ENTRADAS_FILTRO_EN
    localparam int FL = F;
`else
    localparam int FL = 1;
`endif

    logic           clk;
    logic           reset;
    logic [C*N-1:0] In;
    logic [C-1:0]   Enable;
    logic [C*N-1:0] Signreg;
    logic [C-1:0]   Cambio;
    logic [C-1:0]   Clear;
    logic           ev_valid;
    logic           ev_ready;
    logic [CW-1:0]  ev_canal;
    logic [N-1:0]   ev_dato;
    logic           overflow;
    logic           clr_overflow;

    int checks = 0;
    int errors = 0;

    registro_entradas_multi #(.N(N), .C(C), .D(D), .F(F)) dut (
        .clk          (clk),
        .reset        (reset),
        .In           (In),
        .Enable       (Enable),
        .Signreg      (Signreg),
        .Cambio       (Cambio),
        .Clear        (Clear),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_canal     (ev_canal),
        .ev_dato      (ev_dato),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: event queue plus per-channel value, pend, flag and run length
    typedef struct {
        int           ch;
        logic [N-1:0] v;
    } ev_t;

    ev_t          mq[$];
    ev_t          m_ev;
    logic [N-1:0] m_reg  [C];
    logic [N-1:0] m_cand [C];
    int           m_run  [C];
    bit           m_pend [C];
    bit           m_cam  [C];
    bit           m_ovf;
    int           m_g;
    int           m_pushed;
    bit           m_set;
    bit           m_cap;
    logic [N-1:0] m_samp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_ovf = 1'b0;
            for (int c = 0; c < C; c++) begin
                m_reg[c] = '0; m_cand[c] = '0; m_run[c] = 0; m_pend[c] = 1'b0; m_cam[c] = 1'b0;
            end
        end else begin
            m_g = -1;
            for (int c = C - 1; c >= 0; c--) if (m_pend[c]) m_g = c;
            if (mq.size() > 0 && ev_ready) void'(mq.pop_front());
            m_pushed = -1;
            if (m_g >= 0 && mq.size() < D) begin
                m_ev.ch = m_g; m_ev.v = m_reg[m_g];
                mq.push_back(m_ev);
                m_pushed = m_g;
            end
            m_set = 1'b0;
            for (int c = 0; c < C; c++) begin
                m_samp = In[c*N +: N];
                m_cap  = 1'b0;
                if (Enable[c]) begin
                    if (m_samp == m_reg[c]) m_run[c] = 0;
                    else begin
                        if (m_run[c] > 0 && m_samp == m_cand[c]) m_run[c]++;
                        else begin m_cand[c] = m_samp; m_run[c] = 1; end
                        if (m_run[c] >= FL) begin m_cap = 1'b1; m_run[c] = 0; end
                    end
                end
                if (Clear[c]) m_cam[c] = 1'b0;
                if (m_cap) begin
                    if (m_pend[c] && m_pushed != c) m_set = 1'b1;
                    m_reg[c] = m_samp; m_cam[c] = 1'b1; m_pend[c] = 1'b1;
                end else if (m_pushed == c) begin
                    m_pend[c] = 1'b0;
                end
            end
            if (clr_overflow) m_ovf = 1'b0;
            if (m_set) m_ovf = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int fill_ch(input int i);
        return (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 2 : 3);
    endfunction

    task automatic test_reset();
        reset = 1'b0; In = '0; Enable = '0; Clear = '0; ev_ready = 1'b0; clr_overflow = 1'b0;
        repeat (2) tick();
        checks++; if (Signreg !== '0) begin errors++; $display("FAIL reset_signreg got %h exp 0", Signreg); end
        checks++; if (Cambio !== '0) begin errors++; $display("FAIL reset_cambio got %b exp 0", Cambio); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %b exp 0", ev_valid); end
        checks++; if (ev_canal !== '0) begin errors++; $display("FAIL reset_ev_canal got %h exp 0", ev_canal); end
        checks++; if (ev_dato !== '0) begin errors++; $display("FAIL reset_ev_dato got %h exp 0", ev_dato); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        In[2*N +: N] = 25'h1ABCDE; Enable = 4'b0100;
        tick();
        checks++; if (Signreg[2*N +: N] !== 25'h1ABCDE) begin errors++; $display("FAIL single_signreg got %h exp 1abcde", Signreg[2*N +: N]); end
        checks++; if (Cambio !== 4'b0100) begin errors++; $display("FAIL single_cambio got %b exp 0100", Cambio); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", ev_valid); end
        Enable = '0;
        tick();
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ev_valid); end
        checks++; if (ev_canal !== 2'd2) begin errors++; $display("FAIL single_canal got %0d exp 2", ev_canal); end
        checks++; if (ev_dato !== 25'h1ABCDE) begin errors++; $display("FAIL single_dato got %h exp 1abcde", ev_dato); end
        ev_ready = 1'b1; Clear = 4'b1111;
        tick();
        ev_ready = 1'b0; Clear = '0;
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_pop got %b exp 0", ev_valid); end
        checks++; if (Cambio !== 4'b0000) begin errors++; $display("FAIL single_clear got %b exp 0000", Cambio); end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] vals [3];
        int           chs  [3];
        vals[0] = 25'h11; vals[1] = 25'h22; vals[2] = 25'h33;
        chs[0] = 0; chs[1] = 1; chs[2] = 3;
        ev_ready = 1'b1;
        for (int k = 0; k < 3; k++) In[chs[k]*N +: N] = vals[k];
        Enable = 4'b1011;
        tick();
        Enable = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (ev_valid !== 1'b1 || ev_canal !== CW'(chs[k]) || ev_dato !== vals[k]) begin
                errors++; $display("FAIL simul_event%0d got v=%b ch=%0d d=%h exp ch=%0d d=%h", k, ev_valid, ev_canal, ev_dato, chs[k], vals[k]);
            end
        end
        tick();
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL simul_drained got %b exp 0", ev_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow got %b exp 0", overflow); end
        ev_ready = 1'b0;
    endtask

    task automatic test_fifo_full();
        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            In[(i % 4)*N +: N] = N'(100 + i); Enable = '0; Enable[i % 4] = 1'b1;
            tick();
        end
        Enable = '0;
        repeat (3) tick();
        checks++; if (ev_valid !== 1'b1 || ev_canal !== 2'd0 || ev_dato !== N'(100)) begin
            errors++; $display("FAIL full_head got v=%b ch=%0d d=%0d exp ch=0 d=100", ev_valid, ev_canal, ev_dato);
        end
        ev_ready = 1'b1;
        tick();
        for (int j = 1; j <= 8; j++) begin
            checks++; if (ev_valid !== 1'b1 || ev_canal !== CW'(j % 4) || ev_dato !== N'(100 + j)) begin
                errors++; $display("FAIL full_drain%0d got v=%b ch=%0d d=%0d exp ch=%0d d=%0d", j, ev_valid, ev_canal, ev_dato, j % 4, 100 + j);
            end
            tick();
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", ev_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got %b exp 0", overflow); end
        ev_ready = 1'b0;
    endtask

    task automatic test_coalesce();
        int exp_ch;
        int exp_v;
        ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            In[fill_ch(i)*N +: N] = N'(200 + i); Enable = '0; Enable[fill_ch(i)] = 1'b1;
            tick();
        end
        Enable = '0;
        tick();
        for (int v = 5; v <= 7; v++) begin
            In[N +: N] = N'(v); Enable = 4'b0010;
            tick();
        end
        Enable = '0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coal_overflow got %b exp 1", overflow); end
        checks++; if (Signreg[N +: N] !== N'(7)) begin errors++; $display("FAIL coal_signreg got %0d exp 7", Signreg[N +: N]); end
        checks++; if (ev_dato !== N'(200)) begin errors++; $display("FAIL coal_head got %0d exp 200", ev_dato); end
        ev_ready = 1'b1;
        tick();
        for (int j = 1; j <= 8; j++) begin
            exp_ch = (j < 8) ? fill_ch(j) : 1;
            exp_v  = (j < 8) ? 200 + j : 7;
            checks++; if (ev_valid !== 1'b1 || ev_canal !== CW'(exp_ch) || ev_dato !== N'(exp_v)) begin
                errors++; $display("FAIL coal_drain%0d got v=%b ch=%0d d=%0d exp ch=%0d d=%0d", j, ev_valid, ev_canal, ev_dato, exp_ch, exp_v);
            end
            tick();
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL coal_single got %b exp 0", ev_valid); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL coal_clr got %b exp 0", overflow); end
        In[0 +: N] = 25'h55; In[N +: N] = 25'h66; Enable = 4'b0011;
        tick();
        In[N +: N] = 25'h77; Enable = 4'b0010; clr_overflow = 1'b1;
        tick();
        Enable = '0; clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL coal_set_wins got %b exp 1", overflow); end
        checks++; if (ev_canal !== 2'd0 || ev_dato !== 25'h55) begin errors++; $display("FAIL coal_ev0 got ch=%0d d=%h exp ch=0 d=55", ev_canal, ev_dato); end
        tick();
        checks++; if (ev_canal !== 2'd1 || ev_dato !== 25'h77) begin errors++; $display("FAIL coal_ev1 got ch=%0d d=%h exp ch=1 d=77", ev_canal, ev_dato); end
        tick();
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL coal_end got %b exp 0", ev_valid); end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0; ev_ready = 1'b0;
    endtask

`ifdef REGISTRO_ENTRADAS_FILTRO_EN
    task automatic test_filter();
        logic [N-1:0] seq [5];
        logic [N-1:0] exp_v;
        seq[0] = 25'd9; seq[1] = 25'd9; seq[2] = 25'd4; seq[3] = 25'd4; seq[4] = 25'd4;
        for (int k = 0; k < 5; k++) begin
            In[0 +: N] = seq[k]; Enable = 4'b0001;
            tick();
            exp_v = (k == 4) ? 25'd4 : 25'd0;
            checks++; if (Signreg[0 +: N] !== exp_v) begin errors++; $display("FAIL filter_s%0d got %0d exp %0d", k, Signreg[0 +: N], exp_v); end
            In[0 +: N] = 25'd7; Enable = '0;
            tick();
        end
        checks++; if (Cambio[0] !== 1'b1) begin errors++; $display("FAIL filter_cambio got %b exp 1", Cambio[0]); end
        ev_ready = 1'b1; Clear = '1;
        repeat (3) tick();
        ev_ready = 1'b0; Clear = '0;
    endtask
`endif

    task automatic test_reset_mid();
        ev_ready = 1'b0;
        for (int c = 0; c < C; c++) In[c*N +: N] = N'(300 + c);
        Enable = 4'b1111;
        repeat (FL) tick();
        Enable = '0;
        repeat (3) tick();
        checks++; if (Cambio !== 4'b1111) begin errors++; $display("FAIL mid_cambio got %b exp 1111", Cambio); end
        checks++; if (ev_valid !== 1'b1 || ev_dato !== N'(300)) begin errors++; $display("FAIL mid_head got v=%b d=%0d exp 1 300", ev_valid, ev_dato); end
        #2 reset = 1'b0;
        #1;
        checks++; if (Signreg !== '0) begin errors++; $display("FAIL mid_signreg got %h exp 0", Signreg); end
        checks++; if (Cambio !== '0) begin errors++; $display("FAIL mid_cambio0 got %b exp 0", Cambio); end
        checks++; if (ev_valid !== 1'b0 || ev_canal !== '0 || ev_dato !== '0) begin
            errors++; $display("FAIL mid_event got v=%b ch=%0d d=%h exp 0", ev_valid, ev_canal, ev_dato);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b exp 0", overflow); end
        ev_ready = 1'b1;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL mid_after%0d got %b exp 0", k, ev_valid); end
        end
        ev_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [C*N-1:0] exp_sr;
        logic [C-1:0]   exp_cam;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < C; c++) begin
                Enable[c]    = ($urandom_range(0, 3) != 0);
                In[c*N +: N] = N'($urandom_range(0, 3));
                Clear[c]     = ($urandom_range(0, 7) == 0);
            end
            ev_ready     = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            tick();
            for (int c = 0; c < C; c++) begin
                exp_sr[c*N +: N] = m_reg[c];
                exp_cam[c]       = m_cam[c];
            end
            checks++; if (Signreg !== exp_sr) begin errors++; $display("FAIL rnd_signreg@%0d got %h exp %h", k, Signreg, exp_sr); end
            checks++; if (Cambio !== exp_cam) begin errors++; $display("FAIL rnd_cambio@%0d got %b exp %b", k, Cambio, exp_cam); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow@%0d got %b exp %b", k, overflow, m_ovf); end
            checks++; if (ev_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d got %b exp %0d", k, ev_valid, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++; if (ev_canal !== CW'(mq[0].ch) || ev_dato !== mq[0].v) begin
                    errors++; $display("FAIL rnd_event@%0d got ch=%0d d=%h exp ch=%0d d=%h", k, ev_canal, ev_dato, mq[0].ch, mq[0].v);
                end
            end
        end
        Enable = '0; Clear = '0; clr_overflow = 1'b0; ev_ready = 1'b0;
    endtask

    initial begin
        test_reset();
`ifdef REGISTRO_ENTRADAS_FILTRO_EN
        test_filter();
`else
        test_single();
        test_simultaneous();
        test_fifo_full();
        test_coalesce();
`endif
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
